// File: rtl/audio_pkg.sv
// Shared types and sound-effect ROM layout for the audio arbiter.
package audio_pkg;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_BGM  = 2'd1,
    ST_SFX  = 2'd2
  } audio_state_t;

  typedef logic [1:0] sfx_id_t;

  localparam sfx_id_t SFX_NONE = 2'd3;

  // Index 0 drop, 1 line_clear, 2 game_over.
  localparam logic [2:0][13:0] SFX_BASE = {14'd6144, 14'd2048, 14'd0};
  localparam logic [2:0][13:0] SFX_LEN  = {14'd8192, 14'd4096, 14'd2048};

  // First ROM address of an effect.
  function automatic logic [13:0] sfx_base(input sfx_id_t id);
    case (id)
      2'd0:    sfx_base = SFX_BASE[0];
      2'd1:    sfx_base = SFX_BASE[1];
      2'd2:    sfx_base = SFX_BASE[2];
      default: sfx_base = 14'd0;
    endcase
  endfunction

  // Last ROM address of an effect.
  function automatic logic [13:0] sfx_last(input sfx_id_t id);
    case (id)
      2'd0:    sfx_last = SFX_BASE[0] + SFX_LEN[0] - 14'd1;
      2'd1:    sfx_last = SFX_BASE[1] + SFX_LEN[1] - 14'd1;
      2'd2:    sfx_last = SFX_BASE[2] + SFX_LEN[2] - 14'd1;
      default: sfx_last = 14'd0;
    endcase
  endfunction

endpackage

// File: rtl/audio_tick_div.sv
// Note-rate divider: pulses tick on the last cycle of every NOTE_CYCLES period.
module audio_tick_div #(
  parameter int NOTE_CYCLES = 91
) (
  input  logic Clk,
  input  logic Reset,
  input  logic en,
  output logic tick
);

  localparam int CW = (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NOTE_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: wrap at LAST, hold while disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en & (cnt_q == LAST);

endmodule

// File: rtl/audio_arbiter.sv
// BGM sequencer and priority SFX arbiter feeding one sample stream to the codec.
module audio_arbiter
  import audio_pkg::*;
#(
  parameter int BGM_LEN     = 54832,
  parameter int NOTE_CYCLES = 91
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        INIT_FINISH,
  input  logic        data_over,
  output logic        INIT,
  input  logic        pause,
  input  logic [2:0]  sfx_req,
  output logic [16:0] bgm_addr,
  input  logic [15:0] bgm_data,
  output logic [13:0] sfx_addr,
  input  logic [15:0] sfx_data,
  output logic [15:0] sample_out,
  output logic        sfx_busy,
  output logic [1:0]  sfx_id
);

  localparam logic [16:0] BGM_LAST = 17'(BGM_LEN - 1);

  audio_state_t state_q, state_d;
  logic [2:0]   pending_q, pending_d;
  logic [16:0]  bgm_addr_q, bgm_addr_d;
  logic [13:0]  sfx_addr_q, sfx_addr_d;
  sfx_id_t      sfx_id_q, sfx_id_d;
  logic [15:0]  sample_out_q, sample_out_d;

  logic    tick;
  logic    step;
  sfx_id_t hi_id;
  logic    start;
  logic    sfx_end;
  logic [2:0] clr;

  audio_tick_div #(.NOTE_CYCLES(NOTE_CYCLES)) u_tick_div (
    .Clk   (Clk),
    .Reset (Reset),
    .en    (state_q != ST_WAIT),
    .tick  (tick)
  );

  assign step = tick & data_over;

  // Highest-priority pending request.
  always_comb begin
    if (pending_q[2]) begin
      hi_id = 2'd2;
    end else if (pending_q[1]) begin
      hi_id = 2'd1;
    end else if (pending_q[0]) begin
      hi_id = 2'd0;
    end else begin
      hi_id = SFX_NONE;
    end
  end

  // Start/preempt decision on tick; end-of-effect detection on step.
  always_comb begin
    start = 1'b0;
    if (tick && (pending_q != 3'b000)) begin
      case (state_q)
        ST_BGM:  start = 1'b1;
        ST_SFX:  start = (hi_id >= sfx_id_q);
        default: start = 1'b0;
      endcase
    end else begin
      start = 1'b0;
    end
    sfx_end = (state_q == ST_SFX) && step && !start &&
              (sfx_addr_q == sfx_last(sfx_id_q));
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT: state_d = INIT_FINISH ? ST_BGM : ST_WAIT;
      ST_BGM:  state_d = start ? ST_SFX : ST_BGM;
      ST_SFX: begin
        if (start) begin
          state_d = ST_SFX;
        end else if (sfx_end) begin
          state_d = ST_BGM;
        end else begin
          state_d = ST_SFX;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // FSM outputs decoded from the registered state.
  always_comb begin
    INIT     = 1'b1;
    sfx_busy = (state_q == ST_SFX);
  end

  // Datapath next values: pending set/clear, addresses, sample mux.
  always_comb begin
    clr       = start ? (3'b001 << hi_id) : 3'b000;
    // A new pulse for the effect being started re-arms it (set wins).
    pending_d = (pending_q & ~clr) | sfx_req;

    if (step && !pause) begin
      bgm_addr_d = (bgm_addr_q == BGM_LAST) ? 17'd0 : (bgm_addr_q + 17'd1);
    end else begin
      bgm_addr_d = bgm_addr_q;
    end

    if (start) begin
      sfx_addr_d = sfx_base(hi_id);
      sfx_id_d   = hi_id;
    end else if (sfx_end) begin
      sfx_addr_d = sfx_addr_q;
      // With requests still queued the next tick restarts playback.
      sfx_id_d   = (pending_q == 3'b000) ? SFX_NONE : sfx_id_q;
    end else if ((state_q == ST_SFX) && step) begin
      sfx_addr_d = sfx_addr_q + 14'd1;
      sfx_id_d   = sfx_id_q;
    end else begin
      sfx_addr_d = sfx_addr_q;
      sfx_id_d   = sfx_id_q;
    end

    case (state_q)
      ST_SFX:  sample_out_d = sfx_data;
      ST_BGM:  sample_out_d = pause ? 16'd0 : bgm_data;
      default: sample_out_d = 16'd0;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pending_q    <= 3'b000;
      bgm_addr_q   <= 17'd0;
      sfx_addr_q   <= 14'd0;
      sfx_id_q     <= SFX_NONE;
      sample_out_q <= 16'd0;
    end else begin
      pending_q    <= pending_d;
      bgm_addr_q   <= bgm_addr_d;
      sfx_addr_q   <= sfx_addr_d;
      sfx_id_q     <= sfx_id_d;
      sample_out_q <= sample_out_d;
    end
  end

  assign bgm_addr   = bgm_addr_q;
  assign sfx_addr   = sfx_addr_q;
  assign sfx_id     = sfx_id_q;
  assign sample_out = sample_out_q;

endmodule

// File: tb/tb_audio_arbiter.sv
// Scoreboard bench for audio_arbiter with shortened note period and BGM length.
module tb_audio_arbiter;

  localparam int N  = 4;
  localparam int BL = 100;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        INIT_FINISH = 1'b0;
  logic        data_over = 1'b1;
  logic        INIT;
  logic        pause = 1'b0;
  logic [2:0]  sfx_req = 3'b000;
  logic [16:0] bgm_addr;
  logic [15:0] bgm_data;
  logic [13:0] sfx_addr;
  logic [15:0] sfx_data;
  logic [15:0] sample_out;
  logic        sfx_busy;
  logic [1:0]  sfx_id;

  int total = 0;
  int bad   = 0;
  int tcnt  = 0;
  bit running = 1'b0;
  int exp_bgm = 0;
  int exp_q[$];
  int e;

  audio_arbiter #(.BGM_LEN(BL), .NOTE_CYCLES(N)) dut (
    .Clk(Clk), .Reset(Reset), .INIT_FINISH(INIT_FINISH), .data_over(data_over),
    .INIT(INIT), .pause(pause), .sfx_req(sfx_req), .bgm_addr(bgm_addr),
    .bgm_data(bgm_data), .sfx_addr(sfx_addr), .sfx_data(sfx_data),
    .sample_out(sample_out), .sfx_busy(sfx_busy), .sfx_id(sfx_id)
  );

  always #5 Clk = ~Clk;

  // ROM models with one cycle of read latency.
  always @(posedge Clk) begin
    bgm_data <= bgm_addr[15:0] ^ 16'h5A5A;
    sfx_data <= {2'b10, sfx_addr};
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clk1(output bit was_tick);
    bit stepb;
    was_tick = running && (tcnt == N - 1);
    stepb = was_tick && (data_over == 1'b1) && (pause == 1'b0);
    @(posedge Clk); #1;
    if (running) tcnt = (tcnt == N - 1) ? 0 : tcnt + 1;
    if (stepb) exp_bgm = (exp_bgm == BL - 1) ? 0 : exp_bgm + 1;
  endtask

  task automatic cycles(input int n);
    bit t;
    repeat (n) clk1(t);
  endtask

  task automatic next_tick();
    bit t;
    int k;
    t = 1'b0;
    k = 0;
    while (!t && k < 2 * N) begin
      clk1(t);
      k++;
    end
  endtask

  task automatic run_ticks(input int n);
    repeat (n) next_tick();
  endtask

  task automatic pulse(input logic [2:0] r);
    bit t;
    sfx_req = r;
    clk1(t);
    sfx_req = 3'b000;
  endtask

  task automatic do_reset(input logic [2:0] req_during);
    bit t;
    Reset = 1'b1;
    sfx_req = req_during;
    clk1(t);
    clk1(t);
    Reset = 1'b0;
    sfx_req = 3'b000;
    running = 1'b0;
    tcnt = 0;
    exp_bgm = 0;
  endtask

  task automatic do_init();
    bit t;
    INIT_FINISH = 1'b1;
    clk1(t);
    running = 1'b1;
    tcnt = 0;
    INIT_FINISH = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(3'b000);
    cycles(500);
    exp_q.push_back(0); exp_q.push_back(3); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
    e = exp_q.pop_front(); total++;
    if (bgm_addr !== 17'(e)) begin bad++; $display("FAIL reset_bgm_addr: got %0d expected %0d", bgm_addr, e); end
    e = exp_q.pop_front(); total++;
    if (sfx_id !== 2'(e)) begin bad++; $display("FAIL reset_sfx_id: got %0d expected %0d", sfx_id, e); end
    e = exp_q.pop_front(); total++;
    if (sfx_busy !== 1'(e)) begin bad++; $display("FAIL reset_sfx_busy: got %0d expected %0d", sfx_busy, e); end
    e = exp_q.pop_front(); total++;
    if (sample_out !== 16'(e)) begin bad++; $display("FAIL reset_sample: got %0d expected %0d", sample_out, e); end
    e = exp_q.pop_front(); total++;
    if (INIT !== 1'(e)) begin bad++; $display("FAIL reset_init: got %0d expected %0d", INIT, e); end
    e = exp_q.pop_front(); total++;
    if (sfx_addr !== 14'(e)) begin bad++; $display("FAIL reset_sfx_addr: got %0d expected %0d", sfx_addr, e); end
  endtask

  task automatic test_init();
    do_init();
    exp_q.push_back(0);
    cycles(N - 1);
    e = exp_q.pop_front(); total++;
    if (bgm_addr !== 17'(e)) begin bad++; $display("FAIL init_before_tick: got %0d expected %0d", bgm_addr, e); end
    exp_q.push_back(1);
    cycles(1);
    e = exp_q.pop_front(); total++;
    if (bgm_addr !== 17'(e)) begin bad++; $display("FAIL init_first_step: got %0d expected %0d", bgm_addr, e); end
    exp_q.push_back(int'(16'd1 ^ 16'h5A5A));
    cycles(2);
    e = exp_q.pop_front(); total++;
    if (sample_out !== 16'(e)) begin bad++; $display("FAIL init_bgm_sample: got %0h expected %0h", sample_out, e); end
  endtask

  task automatic test_gating_wrap();
    int k;
    next_tick();
    data_over = 1'b0;
    exp_q.push_back(exp_bgm);
    run_ticks(3);
    e = exp_q.pop_front(); total++;
    if (bgm_addr !== 17'(e)) begin bad++; $display("FAIL gating_frozen: got %0d expected %0d", bgm_addr, e); end
    data_over = 1'b1;
    k = 0;
    while (exp_bgm != BL - 1 && k < 2 * BL) begin
      next_tick();
      k++;
    end
    exp_q.push_back(BL - 1);
    e = exp_q.pop_front(); total++;
    if (bgm_addr !== 17'(e)) begin bad++; $display("FAIL wrap_last: got %0d expected %0d", bgm_addr, e); end
    exp_q.push_back(0);
    next_tick();
    e = exp_q.pop_front(); total++;
    if (bgm_addr !== 17'(e)) begin bad++; $display("FAIL wrap_zero: got %0d expected %0d", bgm_addr, e); end
  endtask

  task automatic test_single();
    int b0;
    pulse(3'b010);
    exp_q.push_back(2048); exp_q.push_back(1); exp_q.push_back(1);
    next_tick();
    e = exp_q.pop_front(); total++;
    if (sfx_addr !== 14'(e)) begin bad++; $display("FAIL single_start_addr: got %0d expected %0d", sfx_addr, e); end
    e = exp_q.pop_front(); total++;
    if (sfx_id !== 2'(e)) begin bad++; $display("FAIL single_start_id: got %0d expected %0d", sfx_id, e); end
    e = exp_q.pop_front(); total++;
    if (sfx_busy !== 1'(e)) begin bad++; $display("FAIL single_busy: got %0d expected %0d", sfx_busy, e); end
    b0 = int'(bgm_addr);
    exp_q.push_back(int'({2'b10, 14'd2048}));
    cycles(2);
    e = exp_q.pop_front(); total++;
    if (sample_out !== 16'(e)) begin bad++; $display("FAIL single_sample: got %0h expected %0h", sample_out, e); end
    exp_q.push_back(6143); exp_q.push_back(1);
    run_ticks(4095);
    e = exp_q.pop_front(); total++;
    if (sfx_addr !== 14'(e)) begin bad++; $display("FAIL single_last_addr: got %0d expected %0d", sfx_addr, e); end
    e = exp_q.pop_front(); total++;
    if (sfx_busy !== 1'(e)) begin bad++; $display("FAIL single_busy_last: got %0d expected %0d", sfx_busy, e); end
    exp_q.push_back(0); exp_q.push_back(3); exp_q.push_back((b0 + 4096) % BL);
    next_tick();
    e = exp_q.pop_front(); total++;
    if (sfx_busy !== 1'(e)) begin bad++; $display("FAIL single_end_busy: got %0d expected %0d", sfx_busy, e); end
    e = exp_q.pop_front(); total++;
    if (sfx_id !== 2'(e)) begin bad++; $display("FAIL single_end_id: got %0d expected %0d", sfx_id, e); end
    e = exp_q.pop_front(); total++;
    if (bgm_addr !== 17'(e)) begin bad++; $display("FAIL single_bgm_kept_time: got %0d expected %0d", bgm_addr, e); end
  endtask

  task automatic test_preempt();
    pulse(3'b001);
    exp_q.push_back(0); exp_q.push_back(0);
    next_tick();
    e = exp_q.pop_front(); total++;
    if (sfx_addr !== 14'(e)) begin bad++; $display("FAIL preempt_drop_addr: got %0d expected %0d", sfx_addr, e); end
    e = exp_q.pop_front(); total++;
    if (sfx_id !== 2'(e)) begin bad++; $display("FAIL preempt_drop_id: got %0d expected %0d", sfx_id, e); end
    exp_q.push_back(100);
    run_ticks(100);
    e = exp_q.pop_front(); total++;
    if (sfx_addr !== 14'(e)) begin bad++; $display("FAIL preempt_drop_100: got %0d expected %0d", sfx_addr, e); end
    pulse(3'b100);
    exp_q.push_back(6144); exp_q.push_back(2);
    next_tick();
    e = exp_q.pop_front(); total++;
    if (sfx_addr !== 14'(e)) begin bad++; $display("FAIL preempt_go_addr: got %0d expected %0d", sfx_addr, e); end
    e = exp_q.pop_front(); total++;
    if (sfx_id !== 2'(e)) begin bad++; $display("FAIL preempt_go_id: got %0d expected %0d", sfx_id, e); end
    exp_q.push_back(6145);
    next_tick();
    e = exp_q.pop_front(); total++;
    if (sfx_addr !== 14'(e)) begin bad++; $display("FAIL preempt_no_resume: got %0d expected %0d", sfx_addr, e); end
    do_reset(3'b100);
    exp_q.push_back(0); exp_q.push_back(3);
    e = exp_q.pop_front(); total++;
    if (sfx_busy !== 1'(e)) begin bad++; $display("FAIL midreset_busy: got %0d expected %0d", sfx_busy, e); end
    e = exp_q.pop_front(); total++;
    if (sfx_id !== 2'(e)) begin bad++; $display("FAIL midreset_id: got %0d expected %0d", sfx_id, e); end
    do_init();
    exp_q.push_back(0); exp_q.push_back(2);
    run_ticks(2);
    e = exp_q.pop_front(); total++;
    if (sfx_busy !== 1'(e)) begin bad++; $display("FAIL reset_discard_pending: got %0d expected %0d", sfx_busy, e); end
    e = exp_q.pop_front(); total++;
    if (bgm_addr !== 17'(e)) begin bad++; $display("FAIL reinit_bgm_addr: got %0d expected %0d", bgm_addr, e); end
  endtask

  task automatic test_queued();
    pulse(3'b011);
    exp_q.push_back(2048); exp_q.push_back(1);
    next_tick();
    e = exp_q.pop_front(); total++;
    if (sfx_addr !== 14'(e)) begin bad++; $display("FAIL queued_first_addr: got %0d expected %0d", sfx_addr, e); end
    e = exp_q.pop_front(); total++;
    if (sfx_id !== 2'(e)) begin bad++; $display("FAIL queued_first_id: got %0d expected %0d", sfx_id, e); end
    exp_q.push_back(6143);
    run_ticks(4095);
    e = exp_q.pop_front(); total++;
    if (sfx_addr !== 14'(e)) begin bad++; $display("FAIL queued_lc_last: got %0d expected %0d", sfx_addr, e); end
    exp_q.push_back(0);
    next_tick();
    e = exp_q.pop_front(); total++;
    if (sfx_busy !== 1'(e)) begin bad++; $display("FAIL queued_lc_end: got %0d expected %0d", sfx_busy, e); end
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
    next_tick();
    e = exp_q.pop_front(); total++;
    if (sfx_addr !== 14'(e)) begin bad++; $display("FAIL queued_drop_addr: got %0d expected %0d", sfx_addr, e); end
    e = exp_q.pop_front(); total++;
    if (sfx_id !== 2'(e)) begin bad++; $display("FAIL queued_drop_id: got %0d expected %0d", sfx_id, e); end
    e = exp_q.pop_front(); total++;
    if (sfx_busy !== 1'(e)) begin bad++; $display("FAIL queued_drop_busy: got %0d expected %0d", sfx_busy, e); end
  endtask

  task automatic test_pause();
    int saved;
    do_reset(3'b000);
    do_init();
    run_ticks(2);
    pause = 1'b1;
    saved = exp_bgm;
    exp_q.push_back(saved); exp_q.push_back(0);
    run_ticks(3);
    e = exp_q.pop_front(); total++;
    if (bgm_addr !== 17'(e)) begin bad++; $display("FAIL pause_bgm_hold: got %0d expected %0d", bgm_addr, e); end
    e = exp_q.pop_front(); total++;
    if (sample_out !== 16'(e)) begin bad++; $display("FAIL pause_mute: got %0h expected %0h", sample_out, e); end
    pulse(3'b100);
    exp_q.push_back(2); exp_q.push_back(6144);
    next_tick();
    e = exp_q.pop_front(); total++;
    if (sfx_id !== 2'(e)) begin bad++; $display("FAIL pause_sfx_id: got %0d expected %0d", sfx_id, e); end
    e = exp_q.pop_front(); total++;
    if (sfx_addr !== 14'(e)) begin bad++; $display("FAIL pause_sfx_addr: got %0d expected %0d", sfx_addr, e); end
    exp_q.push_back(int'({2'b10, 14'd6144})); exp_q.push_back(saved);
    cycles(2);
    e = exp_q.pop_front(); total++;
    if (sample_out !== 16'(e)) begin bad++; $display("FAIL pause_sfx_sample: got %0h expected %0h", sample_out, e); end
    e = exp_q.pop_front(); total++;
    if (bgm_addr !== 17'(e)) begin bad++; $display("FAIL pause_bgm_hold_sfx: got %0d expected %0d", bgm_addr, e); end
    pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_init();
    test_gating_wrap();
    test_single();
    test_preempt();
    test_queued();
    test_pause();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
